shift_reg_mode: RTL and testbench

Parametrised multi-mode register: a WIDTH-bit bank of rising-edge flip-flops with synchronous load, shift, rotate, bit-set and bit-clear modes, plus registered per-bit rise/fall edge flags. It is the general-purpose state element used across the codebase in place of single-bit D flip-flop primitives. It serves as a parallel register, a serial shifter or a sticky flag register, selected per cycle by a mode input.

---
 rtl/shift_reg_mode_if.sv | 27 ++
 rtl/shift_reg_mode.sv | 88 ++++++++
 tb/tb_shift_reg_mode.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/shift_reg_mode_if.sv
// Control/data bundle for shift_reg_mode: master drives the operation,
// slave (the register) returns contents, shift-out bit and edge flags.
interface shift_reg_mode_if #(
    parameter int unsigned WIDTH = 8
) ();
    localparam int unsigned MODE_W = 3;

    logic              en;
    logic [MODE_W-1:0] mode;
    logic [WIDTH-1:0]  d;
    logic              sin;
    logic [WIDTH-1:0]  q;
    logic              sout;
    logic [WIDTH-1:0]  rise;
    logic [WIDTH-1:0]  fall;
    logic              changed;

    modport master (
        output en, mode, d, sin,
        input  q, sout, rise, fall, changed
    );

    modport slave (
        input  en, mode, d, sin,
        output q, sout, rise, fall, changed
    );
endinterface

// File: rtl/shift_reg_mode.sv
// Multi-mode WIDTH-bit register: load, shift, rotate, mask set/clear,
// with registered per-bit rise/fall flags describing the latest edge.
module shift_reg_mode #(
    parameter int unsigned     WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input logic             clk,
    input logic             rst,
    shift_reg_mode_if.slave bus
);
    typedef enum logic [2:0] {
        MODE_HOLD = 3'd0,
        MODE_LOAD = 3'd1,
        MODE_SHL  = 3'd2,
        MODE_SHR  = 3'd3,
        MODE_ROTL = 3'd4,
        MODE_ROTR = 3'd5,
        MODE_SET  = 3'd6,
        MODE_CLR  = 3'd7
    } mode_e;

    if (WIDTH < 2) begin : g_width_check
        $error("shift_reg_mode: WIDTH must be at least 2");
    end

    logic [WIDTH-1:0] q_q, q_d;
    logic             sout_q, sout_d;
    logic [WIDTH-1:0] rise_q, rise_d;
    logic [WIDTH-1:0] fall_q, fall_d;
    logic             changed_q, changed_d;

    // Next-state decode; flags fall out of comparing next and current q.
    always_comb begin
        q_d    = q_q;
        sout_d = sout_q;
        if (bus.en) begin
            case (mode_e'(bus.mode))
                MODE_HOLD: q_d = q_q;
                MODE_LOAD: q_d = bus.d;
                MODE_SHL: begin
                    q_d    = {q_q[WIDTH-2:0], bus.sin};
                    sout_d = q_q[WIDTH-1];
                end
                MODE_SHR: begin
                    q_d    = {bus.sin, q_q[WIDTH-1:1]};
                    sout_d = q_q[0];
                end
                MODE_ROTL: begin
                    q_d    = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
                    sout_d = q_q[WIDTH-1];
                end
                MODE_ROTR: begin
                    q_d    = {q_q[0], q_q[WIDTH-1:1]};
                    sout_d = q_q[0];
                end
                MODE_SET: q_d = q_q | bus.d;
                MODE_CLR: q_d = q_q & ~bus.d;
                default:  q_d = q_q;
            endcase
        end
        rise_d    = q_d & ~q_q;
        fall_d    = ~q_d & q_q;
        changed_d = |(rise_d | fall_d);
    end

    // Reset discards everything, including the transition to RESET_VAL.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_q       <= RESET_VAL;
            sout_q    <= 1'b0;
            rise_q    <= '0;
            fall_q    <= '0;
            changed_q <= 1'b0;
        end else begin
            q_q       <= q_d;
            sout_q    <= sout_d;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
            changed_q <= changed_d;
        end
    end

    assign bus.q       = q_q;
    assign bus.sout    = sout_q;
    assign bus.rise    = rise_q;
    assign bus.fall    = fall_q;
    assign bus.changed = changed_q;
endmodule

// File: tb/tb_shift_reg_mode.sv
// Directed + random bench for shift_reg_mode (WIDTH=8, RESET_VAL=8'hA5)
// with a bit-level reference model feeding an expected-result queue.
module tb_shift_reg_mode;
    localparam logic [7:0] RV = 8'hA5;

    typedef struct packed {
        logic [7:0] q;
        logic       sout;
        logic [7:0] rise;
        logic [7:0] fall;
        logic       changed;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t sb[$];
    logic [7:0] mq;
    logic       msout;

    shift_reg_mode_if #(.WIDTH(8)) bus ();

    shift_reg_mode #(.WIDTH(8), .RESET_VAL(RV)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one cycle, push the model's prediction, compare after the edge.
    task automatic step(input logic r, input logic e, input logic [2:0] m,
                        input logic [7:0] dd, input logic s);
        logic [7:0] nq;
        logic       ns;
        exp_t       ex;
        exp_t       got;
        rst      = r;
        bus.en   = e;
        bus.mode = m;
        bus.d    = dd;
        bus.sin  = s;
        nq = mq;
        ns = msout;
        if (r) begin
            nq = RV;
            ns = 1'b0;
        end else if (e) begin
            for (int i = 0; i < 8; i++) begin
                case (m)
                    3'd1: nq[i] = dd[i];
                    3'd2: nq[i] = (i == 0) ? s : mq[(i + 7) % 8];
                    3'd3: nq[i] = (i == 7) ? s : mq[(i + 1) % 8];
                    3'd4: nq[i] = mq[(i + 7) % 8];
                    3'd5: nq[i] = mq[(i + 1) % 8];
                    3'd6: nq[i] = mq[i] | dd[i];
                    3'd7: nq[i] = mq[i] & ~dd[i];
                    default: nq[i] = mq[i];
                endcase
            end
            if (m == 3'd2 || m == 3'd4) ns = mq[7];
            if (m == 3'd3 || m == 3'd5) ns = mq[0];
        end
        ex.q    = nq;
        ex.sout = ns;
        ex.rise = '0;
        ex.fall = '0;
        if (!r) begin
            for (int i = 0; i < 8; i++) begin
                ex.rise[i] = nq[i] && !mq[i];
                ex.fall[i] = !nq[i] && mq[i];
            end
        end
        ex.changed = (ex.rise != 8'h00) || (ex.fall != 8'h00);
        mq    = nq;
        msout = ns;
        sb.push_back(ex);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        chk("sb_q",       32'(bus.q),       32'(got.q));
        chk("sb_sout",    32'(bus.sout),    32'(got.sout));
        chk("sb_rise",    32'(bus.rise),    32'(got.rise));
        chk("sb_fall",    32'(bus.fall),    32'(got.fall));
        chk("sb_changed", 32'(bus.changed), 32'(got.changed));
    endtask

    initial begin
        mq       = 8'h00;
        msout    = 1'b0;
        bus.en   = 1'b0;
        bus.mode = 3'd0;
        bus.d    = 8'h00;
        bus.sin  = 1'b0;

        // Reset overrides a concurrent load
        step(1'b1, 1'b1, 3'd1, 8'hFF, 1'b0);
        chk("rst_q", 32'(bus.q), 32'h A5);
        chk("rst_sout", 32'(bus.sout), 32'h0);
        chk("rst_rise", 32'(bus.rise), 32'h0);
        chk("rst_fall", 32'(bus.fall), 32'h0);
        chk("rst_changed", 32'(bus.changed), 32'h0);

        // Load and flags
        step(1'b0, 1'b1, 3'd1, 8'h0F, 1'b0);
        chk("ld0f_rise", 32'(bus.rise), 32'h0A);
        chk("ld0f_fall", 32'(bus.fall), 32'hA0);
        step(1'b0, 1'b1, 3'd1, 8'hF0, 1'b0);
        chk("ldf0_q", 32'(bus.q), 32'hF0);
        chk("ldf0_rise", 32'(bus.rise), 32'hF0);
        chk("ldf0_fall", 32'(bus.fall), 32'h0F);
        chk("ldf0_changed", 32'(bus.changed), 32'h1);
        step(1'b0, 1'b1, 3'd0, 8'h5A, 1'b1);
        chk("hold_q", 32'(bus.q), 32'hF0);
        chk("hold_changed", 32'(bus.changed), 32'h0);

        // Shift left then right, then idle with en=0
        step(1'b0, 1'b1, 3'd1, 8'h81, 1'b0);
        step(1'b0, 1'b1, 3'd2, 8'h00, 1'b0);
        chk("shl_q", 32'(bus.q), 32'h02);
        chk("shl_sout", 32'(bus.sout), 32'h1);
        step(1'b0, 1'b1, 3'd3, 8'h00, 1'b1);
        chk("shr_q", 32'(bus.q), 32'h81);
        chk("shr_sout", 32'(bus.sout), 32'h0);
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 1'b0, 3'd1, 8'hFF, 1'b1);
            chk("en0_q", 32'(bus.q), 32'h81);
            chk("en0_flags", {22'd0, bus.rise, bus.fall, 1'b0, bus.changed}, 32'h0);
        end

        // Rotate wrap over 8 edges
        step(1'b0, 1'b1, 3'd1, 8'h80, 1'b0);
        for (int k = 0; k < 8; k++) begin
            step(1'b0, 1'b1, 3'd4, 8'h00, 1'b0);
            if (k == 0) begin
                chk("rotl1_q", 32'(bus.q), 32'h01);
                chk("rotl1_sout", 32'(bus.sout), 32'h1);
            end
            chk("rotl_changed", 32'(bus.changed), 32'h1);
        end
        chk("rotl8_q", 32'(bus.q), 32'h80);
        step(1'b0, 1'b1, 3'd5, 8'h00, 1'b0);
        chk("rotr_q", 32'(bus.q), 32'h40);
        chk("rotr_sout", 32'(bus.sout), 32'h0);

        // Rotating all-ones changes nothing
        step(1'b0, 1'b1, 3'd1, 8'hFF, 1'b0);
        step(1'b0, 1'b1, 3'd5, 8'h00, 1'b0);
        chk("rot_ones_changed", 32'(bus.changed), 32'h0);
        chk("rot_ones_sout", 32'(bus.sout), 32'h1);

        // Set/clear masks
        step(1'b0, 1'b1, 3'd1, 8'h00, 1'b0);
        step(1'b0, 1'b1, 3'd6, 8'h11, 1'b0);
        chk("set11_q", 32'(bus.q), 32'h11);
        chk("set11_rise", 32'(bus.rise), 32'h11);
        step(1'b0, 1'b1, 3'd6, 8'h10, 1'b0);
        chk("set10_q", 32'(bus.q), 32'h11);
        chk("set10_changed", 32'(bus.changed), 32'h0);
        step(1'b0, 1'b1, 3'd7, 8'h01, 1'b0);
        chk("clr01_q", 32'(bus.q), 32'h10);
        chk("clr01_fall", 32'(bus.fall), 32'h01);
        step(1'b0, 1'b1, 3'd7, 8'h00, 1'b0);
        chk("clr00_changed", 32'(bus.changed), 32'h0);

        // Reset in the middle of a shift sequence
        step(1'b0, 1'b1, 3'd1, 8'h3C, 1'b0);
        step(1'b0, 1'b1, 3'd2, 8'h00, 1'b1);
        chk("mid_shl_q", 32'(bus.q), 32'h79);
        step(1'b1, 1'b1, 3'd2, 8'h00, 1'b1);
        chk("mid_rst_q", 32'(bus.q), 32'hA5);
        chk("mid_rst_changed", 32'(bus.changed), 32'h0);
        chk("mid_rst_sout", 32'(bus.sout), 32'h0);
        step(1'b0, 1'b1, 3'd2, 8'h00, 1'b0);
        chk("resume_q", 32'(bus.q), 32'h4A);
        chk("resume_sout", 32'(bus.sout), 32'h1);

        // Random back-to-back mix with en toggling and occasional reset
        for (int k = 0; k < 60; k++) begin
            step(($urandom_range(0, 19) == 0), 1'(k % 2 == 0 || $urandom_range(0, 1) == 1),
                 3'($urandom_range(0, 7)), 8'($urandom), 1'($urandom_range(0, 1)));
        end

        chk("sb_empty", 32'(sb.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
